k12a_mem_seq: RTL and testbench

Memory access sequencer directly downstream of the address computation unit. It holds the architectural PC and SP, which feed back into the address adder. It latches addresses computed onto addr_bus and runs byte-wide memory transactions against the 8-bit memory port. 16-bit instruction fetches are performed as two big-endian byte reads.

---
 rtl/k12a_mem_seq_pkg.sv | 29 ++
 rtl/k12a_mem_seq_sp_pc_regs.sv | 26 ++
 rtl/k12a_mem_seq.sv | 168 ++++++++++++++++
 tb/tb_k12a_mem_seq.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/k12a_mem_seq_pkg.sv
`timescale 1ns/1ps
// Shared types for the K12A memory access sequencer: the memory operation
// encoding seen on op_kind and the sequencer state encoding.
package k12a_mem_seq_pkg;

    // Operation requested on op_kind; 2'b11 is reserved and never started.
    typedef enum logic [1:0] {
        MEM_OP_FETCH = 2'd0,
        MEM_OP_READ  = 2'd1,
        MEM_OP_WRITE = 2'd2
    } mem_op_t;

    // Sequencer states: HI/LO are the two bytes of a big-endian fetch.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HI   = 3'd1,
        LO   = 3'd2,
        RD   = 3'd3,
        WR   = 3'd4
    } mem_seq_state_t;

    localparam logic [1:0] MEM_OP_RSVD = 2'b11;

    // True for any op_kind encoding that starts a transaction.
    function automatic logic is_valid_op(input logic [1:0] kind);
        return kind != MEM_OP_RSVD;
    endfunction

endpackage

// File: rtl/k12a_mem_seq_sp_pc_regs.sv
`timescale 1ns/1ps
// Architectural PC and SP registers. Both load from the shared address bus
// and are completely independent of the memory sequencer, so they can be
// written while a memory operation is in flight.
module k12a_sp_pc_regs (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] addr_bus,
    input  logic        pc_load,
    input  logic        sp_load,
    output logic [15:0] pc,
    output logic [15:0] sp
);

    // Load either or both registers from addr_bus; simultaneous loads are legal.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc <= '0;
            sp <= '0;
        end else begin
            if (pc_load) pc <= addr_bus;
            if (sp_load) sp <= addr_bus;
        end
    end

endmodule

// File: rtl/k12a_mem_seq.sv
`timescale 1ns/1ps
// K12A memory access sequencer. Latches an address from addr_bus and runs a
// byte-wide transaction on the memory port: a 16-bit big-endian instruction
// fetch (two reads), a single byte read, or a single byte write. An optional
// per-byte wait limit aborts a transaction whose memory never answers.
module k12a_mem_seq #(
    parameter int unsigned WAIT_TIMEOUT = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] addr_bus,
    input  logic        pc_load,
    input  logic        sp_load,
    input  logic        op_start,
    input  logic [1:0]  op_kind,
    input  logic [7:0]  wr_data,
    output logic [15:0] pc,
    output logic [15:0] sp,
    output logic [15:0] inst,
    output logic [7:0]  rd_data,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready
);
    import k12a_mem_seq_pkg::*;

    // A zero limit disables the abort path entirely; otherwise the abort
    // fires on the WAIT_TIMEOUT-th consecutive cycle without mem_ready.
    localparam bit          WAIT_EN   = (WAIT_TIMEOUT != 0);
    localparam logic [15:0] WAIT_LAST = WAIT_EN ? 16'(WAIT_TIMEOUT - 1) : 16'd0;

    mem_seq_state_t state, state_nxt;
    logic [15:0]    mar, mar_nxt;
    logic [7:0]     wdata, wdata_nxt;
    logic [15:0]    wait_cnt, wait_nxt;
    logic [15:0]    inst_nxt;
    logic [7:0]     rd_nxt;
    logic           done_nxt;
    logic           timeout_nxt;
    logic           in_byte;

    k12a_sp_pc_regs u_regs (
        .clock    (clock),
        .reset_n  (reset_n),
        .addr_bus (addr_bus),
        .pc_load  (pc_load),
        .sp_load  (sp_load),
        .pc       (pc),
        .sp       (sp)
    );

    assign mem_addr  = mar;
    assign mem_wdata = wdata;

    // Next-state, datapath updates and memory strobes for the sequencer.
    always_comb begin
        state_nxt   = state;
        mar_nxt     = mar;
        wdata_nxt   = wdata;
        wait_nxt    = wait_cnt;
        inst_nxt    = inst;
        rd_nxt      = rd_data;
        done_nxt    = 1'b0;
        timeout_nxt = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        in_byte     = 1'b0;

        case (state)
            IDLE: begin
                if (op_start && is_valid_op(op_kind)) begin
                    mar_nxt   = addr_bus;
                    wdata_nxt = wr_data;
                    wait_nxt  = '0;
                    case (op_kind)
                        MEM_OP_FETCH: state_nxt = HI;
                        MEM_OP_READ:  state_nxt = RD;
                        MEM_OP_WRITE: state_nxt = WR;
                        default:      state_nxt = IDLE;
                    endcase
                end
            end
            HI: begin
                mem_re  = 1'b1;
                in_byte = 1'b1;
                if (mem_ready) begin
                    inst_nxt[15:8] = mem_rdata;
                    mar_nxt        = mar + 16'd1;
                    wait_nxt       = '0;
                    state_nxt      = LO;
                end
            end
            LO: begin
                mem_re  = 1'b1;
                in_byte = 1'b1;
                if (mem_ready) begin
                    inst_nxt[7:0] = mem_rdata;
                    wait_nxt      = '0;
                    done_nxt      = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            RD: begin
                mem_re  = 1'b1;
                in_byte = 1'b1;
                if (mem_ready) begin
                    rd_nxt    = mem_rdata;
                    wait_nxt  = '0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WR: begin
                mem_we  = 1'b1;
                in_byte = 1'b1;
                if (mem_ready) begin
                    wait_nxt  = '0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (in_byte && !mem_ready && WAIT_EN) begin
            if (wait_cnt == WAIT_LAST) begin
                wait_nxt    = '0;
                done_nxt    = 1'b1;
                timeout_nxt = 1'b1;
                state_nxt   = IDLE;
            end else begin
                wait_nxt = wait_cnt + 16'd1;
            end
        end
    end

    // Register the sequencer state, datapath latches and status pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            mar      <= '0;
            wdata    <= '0;
            wait_cnt <= '0;
            inst     <= '0;
            rd_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            mar      <= mar_nxt;
            wdata    <= wdata_nxt;
            wait_cnt <= wait_nxt;
            inst     <= inst_nxt;
            rd_data  <= rd_nxt;
            busy     <= (state_nxt != IDLE);
            done     <= done_nxt;
            timeout  <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_k12a_mem_seq.sv
`timescale 1ns/1ps
// Directed bench for the K12A memory sequencer with a byte memory model,
// programmable wait states and a scoreboard of expected transaction results.
module tb_k12a_mem_seq;
    import k12a_mem_seq_pkg::*;

    localparam int unsigned TMO = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] addr_bus = '0;
    logic        pc_load = 1'b0;
    logic        sp_load = 1'b0;
    logic        op_start = 1'b0;
    logic [1:0]  op_kind = '0;
    logic [7:0]  wr_data = '0;
    logic [15:0] pc, sp, inst, mem_addr;
    logic [7:0]  rd_data, mem_wdata, mem_rdata;
    logic        busy, done, timeout, mem_re, mem_we, mem_ready;

    // Scoreboard entry: everything the bench expects from one transaction.
    typedef struct {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [15:0] inst;
        logic [7:0]  rd;
        logic [7:0]  wd;
        logic        tmo;
        int          lat;
        int          n_bytes;
        int          we_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mem [65536];
    logic [15:0] rd_addr_log[$];
    int          wait_cfg = 0;
    int          wait_left = 0;
    bit          hold_low = 1'b0;
    logic [7:0]  cur_wd = '0;
    int          we_total = 0, we_good = 0, overlap = 0;
    logic [15:0] wr_addr_log = '0;
    logic [7:0]  wr_data_log = '0;
    int          cyc = 0;
    int          start_cyc = 0, log_base = 0, we_base = 0, weg_base = 0;
    logic [15:0] model_inst = '0;
    logic [7:0]  model_rd = '0;
    int          checks = 0, errors = 0;

    k12a_mem_seq #(.WAIT_TIMEOUT(TMO)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .addr_bus  (addr_bus),
        .pc_load   (pc_load),
        .sp_load   (sp_load),
        .op_start  (op_start),
        .op_kind   (op_kind),
        .wr_data   (wr_data),
        .pc        (pc),
        .sp        (sp),
        .inst      (inst),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clock = ~clock;

    // Memory model: combinational read data, ready after wait_cfg stalled cycles.
    assign mem_rdata = mem[mem_addr];
    assign mem_ready = !hold_low && (wait_left == 0);

    // Wait-state counter reloads whenever a byte completes or the port is idle.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if ((mem_re || mem_we) && !mem_ready) wait_left <= wait_left - 1;
        else                                  wait_left <= wait_cfg;
    end

    // Port monitor: logs accepted read addresses, write strobes and write data.
    always @(negedge clock) begin
        if (mem_re && mem_ready) rd_addr_log.push_back(mem_addr);
        if (mem_we) begin
            we_total++;
            if (mem_wdata == cur_wd) we_good++;
            if (mem_ready) begin
                wr_addr_log = mem_addr;
                wr_data_log = mem_wdata;
            end
        end
        if (mem_re && mem_we) overlap++;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it and reports tag/observed/expected on failure.
    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every register and strobe must read zero while/after reset.
    task automatic checkReset(input string tag);
        cmp({tag, "_pc"}, 32'(pc), 32'h0);
        cmp({tag, "_sp"}, 32'(sp), 32'h0);
        cmp({tag, "_inst"}, 32'(inst), 32'h0);
        cmp({tag, "_rd"}, 32'(rd_data), 32'h0);
        cmp({tag, "_busy"}, 32'(busy), 32'h0);
        cmp({tag, "_done"}, 32'(done), 32'h0);
        cmp({tag, "_tmo"}, 32'(timeout), 32'h0);
        cmp({tag, "_re"}, 32'(mem_re), 32'h0);
        cmp({tag, "_we"}, 32'(mem_we), 32'h0);
        cmp({tag, "_maddr"}, 32'(mem_addr), 32'h0);
        cmp({tag, "_mwdata"}, 32'(mem_wdata), 32'h0);
    endtask

    // Drive one op_start pulse and push the expected outcome onto the scoreboard.
    task automatic applyStimulus(input logic [1:0] kind, input logic [15:0] addr,
                                 input logic [7:0] wd, input int waits, input bit tmo);
        exp_t e;
        logic [15:0] a1;
        a1 = addr + 16'd1;
        e.kind = kind; e.addr = addr; e.wd = wd; e.tmo = tmo;
        e.inst = model_inst; e.rd = model_rd; e.n_bytes = 0; e.we_cyc = 0;
        if (tmo) begin
            e.lat = 1 + int'(TMO);
        end else if (kind == MEM_OP_FETCH) begin
            e.inst = {mem[addr], mem[a1]};
            e.lat = 3 + 2 * waits;
            e.n_bytes = 2;
        end else if (kind == MEM_OP_READ) begin
            e.rd = mem[addr];
            e.lat = 2 + waits;
            e.n_bytes = 1;
        end else begin
            e.lat = 2 + waits;
            e.we_cyc = 1 + waits;
        end
        model_inst = e.inst;
        model_rd = e.rd;
        sb.push_back(e);
        wait_cfg = waits;
        cur_wd = wd;
        log_base = rd_addr_log.size();
        we_base = we_total;
        weg_base = we_good;
        addr_bus = addr; op_kind = kind; wr_data = wd; op_start = 1'b1;
        @(posedge clock);
        #1;
        start_cyc = cyc;
        op_start = 1'b0; op_kind = MEM_OP_READ; wr_data = ~wd; addr_bus = 16'hDEAD;
    endtask

    // Wait (bounded) for done, pop the scoreboard and compare everything.
    task automatic checkOutput(input string tag);
        exp_t e;
        bit   got;
        int   nb;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            #1;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        cmp({tag, "_done_seen"}, 32'(got), 32'h1);
        if (sb.size() == 0) begin
            cmp({tag, "_sb_empty"}, 32'(sb.size()), 32'h1);
            return;
        end
        e = sb.pop_front();
        nb = rd_addr_log.size() - log_base;
        cmp({tag, "_latency"}, 32'(cyc - start_cyc + 1), 32'(e.lat));
        cmp({tag, "_timeout"}, 32'(timeout), 32'(e.tmo));
        cmp({tag, "_busy"}, 32'(busy), 32'h0);
        cmp({tag, "_inst"}, 32'(inst), 32'(e.inst));
        cmp({tag, "_rd"}, 32'(rd_data), 32'(e.rd));
        cmp({tag, "_nbytes"}, 32'(nb), 32'(e.n_bytes));
        if (nb == e.n_bytes && nb > 0)
            cmp({tag, "_addr0"}, 32'(rd_addr_log[log_base]), 32'(e.addr));
        if (nb == e.n_bytes && nb > 1)
            cmp({tag, "_addr1"}, 32'(rd_addr_log[log_base + 1]), 32'(16'(e.addr + 16'd1)));
        cmp({tag, "_we_cyc"}, 32'(we_total - we_base), 32'(e.we_cyc));
        cmp({tag, "_we_data_ok"}, 32'(we_good - weg_base), 32'(e.we_cyc));
        if (e.we_cyc > 0) begin
            cmp({tag, "_wr_addr"}, 32'(wr_addr_log), 32'(e.addr));
            cmp({tag, "_wr_data"}, 32'(wr_data_log), 32'(e.wd));
        end
        cmp({tag, "_re_we_overlap"}, 32'(overlap), 32'h0);
    endtask

    // Directed sequence: reset, fetches, write, concurrency, timeout, mid-op reset.
    initial begin
        int dones;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
        mem[16'h1234] = 8'hAB; mem[16'h1235] = 8'hCD;
        mem[16'hFFFF] = 8'h12; mem[16'h0000] = 8'h34;
        mem[16'h4000] = 8'h77;

        @(negedge clock);
        #1;
        checkReset("reset");
        @(negedge clock);
        reset_n = 1'b1;
        #1;

        applyStimulus(MEM_OP_FETCH, 16'h1234, 8'h00, 0, 1'b0);
        checkOutput("fetch1234");
        applyStimulus(MEM_OP_FETCH, 16'hFFFF, 8'h00, 0, 1'b0);
        checkOutput("fetch_wrap");
        applyStimulus(MEM_OP_WRITE, 16'h8000, 8'h5A, 2, 1'b0);
        checkOutput("write_wait2");

        // Busy read with PC/SP loads and an ignored op_start in flight.
        applyStimulus(MEM_OP_READ, 16'h4000, 8'h00, 3, 1'b0);
        @(negedge clock); #1;
        addr_bus = 16'h0200; pc_load = 1'b1;
        @(negedge clock); #1;
        pc_load = 1'b0; sp_load = 1'b1; addr_bus = 16'h7FFE;
        op_start = 1'b1; op_kind = MEM_OP_WRITE; wr_data = 8'hEE;
        @(negedge clock); #1;
        sp_load = 1'b0; op_start = 1'b0;
        checkOutput("read_busy");
        cmp("busy_pc", 32'(pc), 32'h0200);
        cmp("busy_sp", 32'(sp), 32'h7FFE);
        @(negedge clock); #1;
        cmp("ignored_start_idle", 32'(busy), 32'h0);

        pc_load = 1'b1; sp_load = 1'b1; addr_bus = 16'h0ABC;
        @(negedge clock); #1;
        pc_load = 1'b0; sp_load = 1'b0;
        cmp("both_pc", 32'(pc), 32'h0ABC);
        cmp("both_sp", 32'(sp), 32'h0ABC);

        op_start = 1'b1; op_kind = 2'b11;
        @(negedge clock); #1;
        op_start = 1'b0;
        cmp("rsvd_busy", 32'(busy), 32'h0);
        cmp("rsvd_re", 32'(mem_re | mem_we), 32'h0);

        hold_low = 1'b1;
        applyStimulus(MEM_OP_READ, 16'h1234, 8'h00, 0, 1'b1);
        checkOutput("timeout");
        hold_low = 1'b0;
        @(negedge clock); #1;
        cmp("tmo_done_pulse", 32'(done), 32'h0);
        cmp("tmo_tmo_pulse", 32'(timeout), 32'h0);
        cmp("tmo_idle", 32'(busy), 32'h0);

        // Reset after the first fetch byte has landed.
        applyStimulus(MEM_OP_FETCH, 16'h1234, 8'h00, 0, 1'b0);
        @(posedge clock); #1;
        cmp("rst_mid_hi", 32'(inst[15:8]), 32'hAB);
        reset_n = 1'b0;
        #1;
        checkReset("rst_mid");
        void'(sb.pop_front());
        model_inst = '0;
        model_rd = '0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock); #1;
            if (done || mem_re || mem_we) dones++;
        end
        cmp("rst_mid_quiet", 32'(dones), 32'h0);
        applyStimulus(MEM_OP_FETCH, 16'h1234, 8'h00, 0, 1'b0);
        checkOutput("fetch_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
